// File: rtl/rob_packet_receiver.sv
// rob_packet_receiver: deserialises the 4-beat decoder and 2-beat RRU packet
// sequences, cross-checks their ROB index and presents one assembled ROB entry write.
`default_nettype none

module rob_packet_receiver #(
  parameter int ROB_DEPTH      = 128,
  parameter bit CHECK_RESERVED = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        dec_valid,
  output logic        dec_ready,
  input  logic [31:0] dec_data,
  input  logic        rru_valid,
  output logic        rru_ready,
  input  logic [31:0] rru_data,
  input  logic        flush,
  output logic        entry_valid,
  input  logic        entry_ready,
  output logic [6:0]  entry_rob_index,
  output logic        entry_is_branch,
  output logic        entry_is_taken,
  output logic [4:0]  entry_dst_arch,
  output logic [8:0]  entry_op_id,
  output logic [31:0] entry_imm,
  output logic [63:0] entry_pc,
  output logic [7:0]  entry_dst_phy,
  output logic [7:0]  entry_src_phy1,
  output logic [7:0]  entry_src_phy2,
  output logic [7:0]  entry_prev_phy,
  output logic        err_mismatch,
  output logic        err_reserved
);

  localparam logic [7:0] DEPTH_LIMIT = 8'(ROB_DEPTH);

  typedef enum logic [2:0] {D1, D2, D3, D4, DDONE} dec_state_t;
  typedef enum logic [1:0] {R1, R2, RDONE} rru_state_t;

  dec_state_t dec_state, dec_next;
  rru_state_t rru_state, rru_next;

  logic [6:0]  dec_idx;
  logic        dec_br, dec_tk;
  logic [4:0]  dec_dst;
  logic [8:0]  dec_op;
  logic [31:0] dec_imm, dec_pc_hi, dec_pc_lo;
  logic [6:0]  rru_idx;
  logic [7:0]  rru_dst, rru_s1, rru_s2, rru_prev;

  logic dec_fire, rru_fire, both_done, commit, idx_match, load, drain;
  logic dec_bad, rru_bad;

  assign dec_fire  = dec_valid && dec_ready;
  assign rru_fire  = rru_valid && rru_ready;
  assign both_done = (dec_state == DDONE) && (rru_state == RDONE);
  assign commit    = both_done && (!entry_valid || entry_ready) && !flush;
  assign idx_match = (dec_idx == rru_idx);
  assign load      = commit && idx_match;
  assign drain     = entry_valid && entry_ready;

  // Protocol errors flag the beat but never stall or drop it.
  assign dec_bad = dec_fire && (dec_state == D1) &&
                   (({1'b0, dec_data[31:25]} >= DEPTH_LIMIT) ||
                    (CHECK_RESERVED && ((|dec_data[24:23]) || (|dec_data[20:14]))));
  assign rru_bad = rru_fire &&
                   (((rru_state == R1) &&
                     (({1'b0, rru_data[31:25]} >= DEPTH_LIMIT) ||
                      (CHECK_RESERVED && rru_data[24]))) ||
                    ((rru_state == R2) && CHECK_RESERVED && (|rru_data[31:8])));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_state <= D1;
      rru_state <= R1;
    end else begin
      dec_state <= dec_next;
      rru_state <= rru_next;
    end
  end

  always_comb begin
    dec_next  = dec_state;
    dec_ready = 1'b0;
    if (flush) begin
      dec_next = D1;
    end else begin
      dec_ready = (dec_state != DDONE);
      if (commit) begin
        dec_next = D1;
      end else if (dec_valid) begin
        case (dec_state)
          D1:      dec_next = D2;
          D2:      dec_next = D3;
          D3:      dec_next = D4;
          D4:      dec_next = DDONE;
          default: dec_next = DDONE;
        endcase
      end
    end
  end

  always_comb begin
    rru_next  = rru_state;
    rru_ready = 1'b0;
    if (flush) begin
      rru_next = R1;
    end else begin
      rru_ready = (rru_state != RDONE);
      if (commit) begin
        rru_next = R1;
      end else if (rru_valid) begin
        case (rru_state)
          R1:      rru_next = R2;
          R2:      rru_next = RDONE;
          default: rru_next = RDONE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dec_idx   <= '0;
      dec_br    <= 1'b0;
      dec_tk    <= 1'b0;
      dec_dst   <= '0;
      dec_op    <= '0;
      dec_imm   <= '0;
      dec_pc_hi <= '0;
      dec_pc_lo <= '0;
      rru_idx   <= '0;
      rru_dst   <= '0;
      rru_s1    <= '0;
      rru_s2    <= '0;
      rru_prev  <= '0;
    end else begin
      if (dec_fire) begin
        case (dec_state)
          D1: begin
            dec_idx <= dec_data[31:25];
            dec_br  <= dec_data[22];
            dec_tk  <= dec_data[21];
            dec_dst <= dec_data[13:9];
            dec_op  <= dec_data[8:0];
          end
          D2:      dec_imm   <= dec_data;
          D3:      dec_pc_hi <= dec_data;
          D4:      dec_pc_lo <= dec_data;
          default: ;
        endcase
      end
      if (rru_fire) begin
        case (rru_state)
          R1: begin
            rru_idx <= rru_data[31:25];
            rru_dst <= rru_data[23:16];
            rru_s1  <= rru_data[15:8];
            rru_s2  <= rru_data[7:0];
          end
          R2:      rru_prev <= rru_data[7:0];
          default: ;
        endcase
      end
    end
  end

  // Output stage: flush drops a pending entry; a drain and a new commit may share a cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_valid     <= 1'b0;
      entry_rob_index <= '0;
      entry_is_branch <= 1'b0;
      entry_is_taken  <= 1'b0;
      entry_dst_arch  <= '0;
      entry_op_id     <= '0;
      entry_imm       <= '0;
      entry_pc        <= '0;
      entry_dst_phy   <= '0;
      entry_src_phy1  <= '0;
      entry_src_phy2  <= '0;
      entry_prev_phy  <= '0;
      err_mismatch    <= 1'b0;
      err_reserved    <= 1'b0;
    end else begin
      err_mismatch <= commit && !idx_match;
      err_reserved <= dec_bad || rru_bad;
      if (flush) begin
        entry_valid <= 1'b0;
      end else if (load) begin
        entry_valid <= 1'b1;
      end else if (drain) begin
        entry_valid <= 1'b0;
      end
      if (load) begin
        entry_rob_index <= dec_idx;
        entry_is_branch <= dec_br;
        entry_is_taken  <= dec_tk;
        entry_dst_arch  <= dec_dst;
        entry_op_id     <= dec_op;
        entry_imm       <= dec_imm;
        entry_pc        <= {dec_pc_hi, dec_pc_lo};
        entry_dst_phy   <= rru_dst;
        entry_src_phy1  <= rru_s1;
        entry_src_phy2  <= rru_s2;
        entry_prev_phy  <= rru_prev;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_rob_packet_receiver.sv
// Testbench for rob_packet_receiver: directed table, multi-cycle corner sequences,
// and randomized packet traffic against a transaction-level reference model.
`default_nettype none

module tb_rob_packet_receiver;

  localparam int DEPTH = 64;
  localparam int NRND  = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dec_valid = 1'b0, rru_valid = 1'b0, flush = 1'b0, entry_ready = 1'b1;
  logic [31:0] dec_data = '0, rru_data = '0;
  logic        dec_ready, rru_ready, entry_valid, entry_is_branch, entry_is_taken;
  logic [6:0]  entry_rob_index;
  logic [4:0]  entry_dst_arch;
  logic [8:0]  entry_op_id;
  logic [31:0] entry_imm;
  logic [63:0] entry_pc;
  logic [7:0]  entry_dst_phy, entry_src_phy1, entry_src_phy2, entry_prev_phy;
  logic        err_mismatch, err_reserved;

  rob_packet_receiver #(.ROB_DEPTH(DEPTH), .CHECK_RESERVED(1'b1)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_valid(dec_valid), .dec_ready(dec_ready), .dec_data(dec_data),
    .rru_valid(rru_valid), .rru_ready(rru_ready), .rru_data(rru_data),
    .flush(flush),
    .entry_valid(entry_valid), .entry_ready(entry_ready),
    .entry_rob_index(entry_rob_index), .entry_is_branch(entry_is_branch),
    .entry_is_taken(entry_is_taken), .entry_dst_arch(entry_dst_arch),
    .entry_op_id(entry_op_id), .entry_imm(entry_imm), .entry_pc(entry_pc),
    .entry_dst_phy(entry_dst_phy), .entry_src_phy1(entry_src_phy1),
    .entry_src_phy2(entry_src_phy2), .entry_prev_phy(entry_prev_phy),
    .err_mismatch(err_mismatch), .err_reserved(err_reserved)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0]  idx;
    logic        br, tk;
    logic [4:0]  dst;
    logic [8:0]  op;
    logic [31:0] imm;
    logic [63:0] pc;
    logic [7:0]  dp, s1, s2, pp;
  } ent_t;

  typedef struct {
    logic [31:0] d1, d2, d3, d4, r1, r2;
    logic        ent;
    int          mis, res;
    ent_t        exp;
  } vec_t;

  int n_cmp = 0, n_bad = 0;
  int mis_cnt = 0, res_cnt = 0;

  always @(posedge clk) begin
    if (err_mismatch) mis_cnt++;
    if (err_reserved) res_cnt++;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [150:0] act, input logic [150:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_d1(logic [6:0] i, logic br, logic tk, logic [4:0] dst, logic [8:0] op);
    return {i, 2'b00, br, tk, 7'b0, dst, op};
  endfunction

  function automatic logic [31:0] mk_r1(logic [6:0] i, logic [7:0] dp, logic [7:0] s1, logic [7:0] s2);
    return {i, 1'b0, dp, s1, s2};
  endfunction

  function automatic ent_t mk_ent(logic [6:0] i, logic br, logic tk, logic [4:0] dst, logic [8:0] op,
                                  logic [31:0] imm, logic [63:0] pc, logic [7:0] dp, logic [7:0] s1,
                                  logic [7:0] s2, logic [7:0] pp);
    ent_t e;
    e.idx = i; e.br = br; e.tk = tk; e.dst = dst; e.op = op; e.imm = imm; e.pc = pc;
    e.dp = dp; e.s1 = s1; e.s2 = s2; e.pp = pp;
    return e;
  endfunction

  function automatic logic [150:0] pack_ent(ent_t e);
    return {e.idx, e.br, e.tk, e.dst, e.op, e.imm, e.pc, e.dp, e.s1, e.s2, e.pp};
  endfunction

  function automatic logic [150:0] pack_dut();
    return {entry_rob_index, entry_is_branch, entry_is_taken, entry_dst_arch, entry_op_id,
            entry_imm, entry_pc, entry_dst_phy, entry_src_phy1, entry_src_phy2, entry_prev_phy};
  endfunction

  // Directed beat tasks: entered and left on a falling edge.
  task automatic dec_beat(input logic [31:0] d);
    int n;
    n = 0;
    dec_valid = 1'b1;
    dec_data  = d;
    while (!dec_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("dec_beat_timeout", 151'(0), 151'(1));
    @(negedge clk);
    dec_valid = 1'b0;
  endtask

  task automatic rru_beat(input logic [31:0] d);
    int n;
    n = 0;
    rru_valid = 1'b1;
    rru_data  = d;
    while (!rru_ready && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) check("rru_beat_timeout", 151'(0), 151'(1));
    @(negedge clk);
    rru_valid = 1'b0;
  endtask

  task automatic send_pair(input logic [31:0] d1, d2, d3, d4, r1, r2);
    dec_beat(d1); dec_beat(d2); dec_beat(d3); dec_beat(d4);
    rru_beat(r1); rru_beat(r2);
  endtask

  vec_t        tbl [6];
  logic [31:0] rd [NRND][4];
  logic [31:0] rr [NRND][2];
  ent_t        exp_q[$];

  initial begin
    int mis0, res0, exp_mis;
    bit dec_done, rru_done;

    tbl[0] = '{32'h0A40_2A05, 32'h0000_1234, 32'h0000_0001, 32'h8000_0000, 32'h0A11_2233, 32'h0000_0044,
               1'b1, 0, 0, mk_ent(7'd5, 1, 0, 5'd21, 9'd5, 32'h1234, 64'h1_8000_0000, 8'h11, 8'h22, 8'h33, 8'h44)};
    tbl[1] = '{32'h0600_0000, 0, 0, 0, 32'h0800_0000, 0,
               1'b0, 1, 0, mk_ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0)};
    tbl[2] = '{32'h1220_07FF, 32'hDEAD_BEEF, 32'h0000_00AB, 32'h1234_5678, 32'h12A1_B2C3, 32'h0000_00FE,
               1'b1, 0, 0, mk_ent(7'd9, 0, 1, 5'd3, 9'h1FF, 32'hDEAD_BEEF, 64'h0000_00AB_1234_5678,
                                  8'hA1, 8'hB2, 8'hC3, 8'hFE)};
    tbl[3] = '{32'h0E80_0001, 0, 0, 0, 32'h0E01_0203, 32'h0000_0004,
               1'b1, 0, 1, mk_ent(7'd7, 0, 0, 0, 9'd1, 0, 0, 8'h01, 8'h02, 8'h03, 8'h04)};
    tbl[4] = '{32'hFE40_0000, 0, 0, 0, 32'hFE05_0607, 32'h0000_0008,
               1'b1, 0, 2, mk_ent(7'd127, 1, 0, 0, 0, 0, 0, 8'h05, 8'h06, 8'h07, 8'h08)};
    tbl[5] = '{0, 0, 0, 0, 0, 32'h0100_0009,
               1'b1, 0, 1, mk_ent(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8'h09)};

    // Reset state
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_entry_valid", 151'(entry_valid), 151'(0));
    check("reset_errs", 151'({err_mismatch, err_reserved}), 151'(0));
    check("reset_readies", 151'({dec_ready, rru_ready}), 151'(2'b11));
    check("reset_entry_fields", pack_dut(), 151'(0));
    @(negedge clk);

    // Table-driven packets with entry_ready held high
    entry_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mis0 = mis_cnt;
      res0 = res_cnt;
      send_pair(tbl[i].d1, tbl[i].d2, tbl[i].d3, tbl[i].d4, tbl[i].r1, tbl[i].r2);
      @(negedge clk);
      check($sformatf("vec%0d_valid", i), 151'(entry_valid), 151'(tbl[i].ent));
      if (tbl[i].ent) check($sformatf("vec%0d_entry", i), pack_dut(), pack_ent(tbl[i].exp));
      @(negedge clk);
      check($sformatf("vec%0d_mismatch_pulses", i), 151'(mis_cnt - mis0), 151'(tbl[i].mis));
      check($sformatf("vec%0d_reserved_pulses", i), 151'(res_cnt - res0), 151'(tbl[i].res));
      check($sformatf("vec%0d_drained", i), 151'(entry_valid), 151'(0));
    end

    // RRU finishes long before the decoder
    rru_beat(mk_r1(7'd16, 8'h61, 8'h62, 8'h63));
    rru_beat(32'h0000_0064);
    check("rru_wait_ready", 151'(rru_ready), 151'(0));
    repeat (10) @(negedge clk);
    check("rru_wait_still", 151'({rru_ready, entry_valid}), 151'(0));
    dec_beat(mk_d1(7'd16, 1, 1, 5'd2, 9'd33));
    dec_beat(32'h0000_0AAA); dec_beat(32'h0000_0002); dec_beat(32'h0000_0003);
    @(negedge clk);
    check("rru_first_entry", pack_dut(),
          pack_ent(mk_ent(7'd16, 1, 1, 5'd2, 9'd33, 32'hAAA, 64'h2_0000_0003, 8'h61, 8'h62, 8'h63, 8'h64)));
    check("rru_first_valid", 151'(entry_valid), 151'(1));
    @(negedge clk);

    // Back-pressure: second pair stalls in the done states behind a held entry
    entry_ready = 1'b0;
    send_pair(mk_d1(7'd20, 0, 0, 5'd1, 9'd1), 32'h20, 32'h0, 32'h20, mk_r1(7'd20, 8'h20, 8'h21, 8'h22), 32'h23);
    @(negedge clk);
    send_pair(mk_d1(7'd21, 0, 0, 5'd1, 9'd2), 32'h21, 32'h0, 32'h21, mk_r1(7'd21, 8'h30, 8'h31, 8'h32), 32'h33);
    repeat (3) @(negedge clk);
    check("bp_held_entry", {entry_valid, entry_rob_index, entry_imm}, 151'({1'b1, 7'd20, 32'h20}));
    check("bp_stalled_readies", 151'({dec_ready, rru_ready}), 151'(0));
    entry_ready = 1'b1;
    @(negedge clk);
    entry_ready = 1'b0;
    check("bp_second_entry", pack_dut(),
          pack_ent(mk_ent(7'd21, 0, 0, 5'd1, 9'd2, 32'h21, 64'h21, 8'h30, 8'h31, 8'h32, 8'h33)));
    check("bp_second_valid_ready", 151'({entry_valid, dec_ready, rru_ready}), 151'(3'b111));

    // Flush mid-sequence with the second entry still pending
    dec_beat(mk_d1(7'd30, 0, 0, 0, 0));
    dec_beat(32'h30);
    flush = 1'b1;
    #1;
    check("flush_readies_low", 151'({dec_ready, rru_ready}), 151'(0));
    @(negedge clk);
    flush = 1'b0;
    #1;
    check("flush_after", 151'({entry_valid, dec_ready, rru_ready}), 151'(3'b011));
    entry_ready = 1'b1;
    mis0 = mis_cnt;
    send_pair(mk_d1(7'd31, 1, 0, 5'd9, 9'd99), 32'h31, 32'h5, 32'h6, mk_r1(7'd31, 8'h41, 8'h42, 8'h43), 32'h44);
    @(negedge clk);
    check("flush_fresh_entry", {entry_valid, pack_dut()[149:0]},
          {1'b1, pack_ent(mk_ent(7'd31, 1, 0, 5'd9, 9'd99, 32'h31, 64'h5_0000_0006,
                                 8'h41, 8'h42, 8'h43, 8'h44))[149:0]});
    @(negedge clk);
    check("flush_no_mismatch", 151'(mis_cnt - mis0), 151'(0));

    // Asynchronous reset clears a pending entry without a clock edge
    entry_ready = 1'b0;
    send_pair(mk_d1(7'd40, 0, 1, 0, 0), 32'h40, 0, 0, mk_r1(7'd40, 1, 2, 3), 32'h4);
    @(negedge clk);
    dec_beat(mk_d1(7'd41, 0, 0, 0, 0));
    #2 rst_n = 1'b0;
    #1;
    check("async_reset", {entry_valid, pack_dut()[149:0]}, 151'(0));
    @(negedge clk);
    rst_n = 1'b1;
    entry_ready = 1'b1;
    @(negedge clk);

    // Randomized traffic: the k-th decoder packet pairs with the k-th RRU packet
    exp_mis = 0;
    for (int k = 0; k < NRND; k++) begin
      int idx, ridx;
      ent_t e;
      idx  = $urandom_range(0, DEPTH - 1);
      ridx = ($urandom_range(0, 3) == 0) ? (idx + $urandom_range(1, DEPTH - 1)) % DEPTH : idx;
      e = mk_ent(7'(idx), 1'($urandom), 1'($urandom), 5'($urandom), 9'($urandom), $urandom,
                 {$urandom, $urandom}, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      rd[k][0] = mk_d1(e.idx, e.br, e.tk, e.dst, e.op);
      rd[k][1] = e.imm;
      rd[k][2] = e.pc[63:32];
      rd[k][3] = e.pc[31:0];
      rr[k][0] = mk_r1(7'(ridx), e.dp, e.s1, e.s2);
      rr[k][1] = {24'h0, e.pp};
      if (ridx == idx) exp_q.push_back(e);
      else exp_mis++;
    end
    mis0 = mis_cnt;
    res0 = res_cnt;
    dec_done = 0;
    rru_done = 0;
    fork
      begin
        @(posedge clk); #1;
        for (int k = 0; k < NRND; k++) begin
          for (int b = 0; b < 4; b++) begin
            bit acc;
            int n;
            dec_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            dec_valid = 1'b1;
            dec_data  = rd[k][b];
            acc = 0; n = 0;
            while (!acc && n < 500) begin
              @(negedge clk); acc = dec_ready; @(posedge clk); #1; n++;
            end
            if (!acc) check("rnd_dec_timeout", 151'(0), 151'(1));
          end
        end
        dec_valid = 1'b0;
        dec_done = 1;
      end
      begin
        @(posedge clk); #1;
        for (int k = 0; k < NRND; k++) begin
          for (int b = 0; b < 2; b++) begin
            bit acc;
            int n;
            rru_valid = 1'b0;
            repeat ($urandom_range(0, 4)) begin @(posedge clk); #1; end
            rru_valid = 1'b1;
            rru_data  = rr[k][b];
            acc = 0; n = 0;
            while (!acc && n < 500) begin
              @(negedge clk); acc = rru_ready; @(posedge clk); #1; n++;
            end
            if (!acc) check("rnd_rru_timeout", 151'(0), 151'(1));
          end
        end
        rru_valid = 1'b0;
        rru_done = 1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!(dec_done && rru_done && exp_q.size() == 0) && cyc < 20000) begin
          @(negedge clk);
          if (entry_valid && entry_ready) begin
            if (exp_q.size() == 0) check("rnd_unexpected_entry", 151'(1), 151'(0));
            else check("rnd_entry", pack_dut(), pack_ent(exp_q.pop_front()));
          end
          @(posedge clk); #1;
          entry_ready = ($urandom_range(0, 2) != 0);
          cyc++;
        end
      end
    join
    entry_ready = 1'b1;
    repeat (4) @(negedge clk);
    check("rnd_all_entries_seen", 151'(exp_q.size()), 151'(0));
    check("rnd_mismatch_pulses", 151'(mis_cnt - mis0), 151'(exp_mis));
    check("rnd_no_reserved", 151'(res_cnt - res0), 151'(0));
    check("rnd_idle_end", 151'({entry_valid, dec_ready, rru_ready}), 151'(3'b011));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/rob_packet_receiver.md
Name: rob_packet_receiver

Overview:
- ROB-side receive end of the 32-bit packet links from the Instruction Decoder and the Register Renaming Unit.
- Deserialises the 4-beat decoder sequence (DecoderToRob1..4) and the 2-beat RRU sequence (RruToRob1..2).
- Checks that both sequences carry the same ROB index, then presents one assembled ROB entry write to the ROB storage array.
- Sits between the packet links and the ROB entry array.

Parameters:
- ROB_DEPTH, 128, number of ROB entries; robIndex >= ROB_DEPTH is a protocol error.
- CHECK_RESERVED, 1, when 1 a nonzero reserved field raises err_reserved (the beat is still accepted).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- dec_valid  in  1  decoder beat valid.
- dec_ready  out  1  receiver accepts decoder beat.
- dec_data  in  32  decoder packet beat.
- rru_valid  in  1  RRU beat valid.
- rru_ready  out  1  receiver accepts RRU beat.
- rru_data  in  32  RRU packet beat.
- flush  in  1  branch recovery; discards partial and pending state.
- entry_valid  out  1  assembled entry available.
- entry_ready  in  1  ROB array accepts entry.
- entry_rob_index  out  7  ROB index.
- entry_is_branch  out  1  branch instruction flag.
- entry_is_taken  out  1  predicted-taken flag.
- entry_dst_arch  out  5  destination architectural register.
- entry_op_id  out  9  operation id.
- entry_imm  out  32  lower immediate.
- entry_pc  out  64  {upperPC, lowerPC}.
- entry_dst_phy, entry_src_phy1, entry_src_phy2, entry_prev_phy  out  8 each  physical registers.
- err_mismatch  out  1  one-cycle pulse: decoder and RRU ROB indices differ.
- err_reserved  out  1  one-cycle pulse: nonzero reserved bits or index out of range.

Behaviour:
- Reset: both FSMs go to their first-beat state; entry_valid=0, err_* = 0, all entry_* = 0.
- Beat transfer: a beat transfers on valid&&ready at the rising edge. Data must be held by the sender while valid is high and ready is low.
- Decoder FSM: D1 -> D2 -> D3 -> D4 -> DDONE, advancing one state per accepted beat.
  - D1 beat fields: [31:25] robIndex, [24:23] reserved, [22] isBranch, [21] isTaken, [20:14] reserved, [13:9] dstArch, [8:0] opId.
  - D2 = immediate, D3 = upper PC, D4 = lower PC.
  - dec_ready = (state != DDONE) && !flush.
- RRU FSM: R1 -> R2 -> RDONE.
  - R1 beat fields: [31:25] robIndex, [24] reserved, [23:16] dstPhy, [15:8] src1, [7:0] src2.
  - R2 beat fields: [31:8] reserved, [7:0] prevPhy.
  - rru_ready = (state != RDONE) && !flush.
- The two channels run independently; either may finish first and wait in its DONE state.
- Commit condition: DDONE && RDONE && (!entry_valid || entry_ready).
  - If the indices match: load the entry_* registers, set entry_valid=1 next cycle, both FSMs return to D1/R1 in the same cycle. Latency is one cycle from the later final beat.
  - If the indices differ: pulse err_mismatch for one cycle, discard both sequences, both FSMs return to D1/R1, entry_valid is unchanged.
- Output hold: entry_valid stays high with stable entry_* until entry_ready. Accumulation of the next packet proceeds while an entry is pending. Commit and drain in the same cycle are allowed (back-to-back).
- err_reserved:
  - Pulses the cycle after an accepted beat with nonzero reserved bits (when CHECK_RESERVED=1).
  - Pulses the cycle after an accepted D1/R1 beat whose robIndex >= ROB_DEPTH (always checked).
  - The beat is still consumed.
- flush (synchronous, highest priority):
  - Both readies are 0 during the flush cycle.
  - Next cycle: FSMs in D1/R1, entry_valid=0, the pending entry is dropped.
  - A commit in the flush cycle is suppressed.
- Asserting rst_n low mid-sequence clears everything immediately, asynchronously.

Test Plan:
- Decoder beats 0x0A40_2A05, 0x0000_1234, 0x0000_0001, 0x8000_0000, then RRU beats 0x0A11_2233, 0x0000_0044, entry_ready=1 -> one cycle after the last beat: entry_valid=1, rob_index=5, is_branch=1, is_taken=0, dst_arch=21, op_id=5, imm=0x1234, pc=0x1_8000_0000, dst_phy=0x11, src1=0x22, src2=0x33, prev_phy=0x44.
- RRU sequence completes 10 cycles before the decoder sequence -> rru_ready=0 while waiting; the entry appears one cycle after decoder beat 4.
- Decoder robIndex 3, RRU robIndex 4 -> err_mismatch pulses once, entry_valid stays 0, next matched pair commits normally.
- entry_ready held 0 while a second full pair arrives -> the first entry is held stable, both FSMs stall in DDONE/RDONE; entry_ready=1 for one cycle -> the second entry appears the next cycle with no beat lost.
- flush asserted after decoder beat 2 with an entry pending -> the next cycle has entry_valid=0 and both readies high; a fresh 4+2 sequence commits correctly.
- D1 with bits [24:23]=2'b01, and separately robIndex=127 with ROB_DEPTH=64 -> err_reserved pulses once per case, the beat is accepted, and the sequence continues.
